// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the game-flow sequencer.
//   seq_state_t : encoded sequencer state, also exported on the 'state' port
//   COUNTER_W   : width of every frame counter in the sequencer
package game_pkg;

    localparam int unsigned COUNTER_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        CRASH = 3'd2,
        SPIN  = 3'd3,
        OVER  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/frame_down_counter.sv
// frame_down_counter: loadable down-counter advanced once per enabled frame.
// Ports:
//   clk, resetN  : clock, asynchronous active-low reset
//   i_frame_en   : decrement by one (saturates at zero); low = hold
//   i_load       : load i_load_val (overrides decrement)
//   i_clear      : force to zero (overrides load)
//   i_load_val   : value for i_load
//   o_count      : current count
//   o_zero       : count is zero
module frame_down_counter
    import game_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 i_frame_en,
    input  logic                 i_load,
    input  logic                 i_clear,
    input  logic [COUNTER_W-1:0] i_load_val,
    output logic [COUNTER_W-1:0] o_count,
    output logic                 o_zero
);

    logic [COUNTER_W-1:0] r_count;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_frame_en && (r_count != '0)) begin
            r_count <= r_count - COUNTER_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/collision_sequencer.sv
// collision_sequencer: frame-synchronous game-flow controller for the player car.
// Collision flags are latched across a frame and evaluated once per startOfFrame.
// Ports:
//   clk, resetN            : clock, asynchronous active-low reset
//   startOfFrame           : one-clk pulse per video frame
//   start_key              : start / restart request (level)
//   *_collision, gameOver  : pixel-rate flags from the collision detector
//   state                  : encoded sequencer state
//   freeze/skid/invulnerable/blink/game_over_out : levels to datapath blocks
//   health_dec/truck_hit/fuel_refill/new_game    : one-clk pulses
module collision_sequencer
    import game_pkg::*;
#(
    parameter int unsigned CRASH_FRAMES  = 64,
    parameter int unsigned OIL_FRAMES    = 32,
    parameter int unsigned INVULN_FRAMES = 96,
    parameter int unsigned BLINK_BIT     = 2
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       start_key,
    input  logic       car_collision,
    input  logic       truck_collision,
    input  logic       oil_collision,
    input  logic       fuel_symbol_collision,
    input  logic       gameOver,
    output logic [2:0] state,
    output logic       freeze,
    output logic       skid,
    output logic       invulnerable,
    output logic       blink,
    output logic       health_dec,
    output logic       truck_hit,
    output logic       fuel_refill,
    output logic       new_game,
    output logic       game_over_out
);

    seq_state_t           r_state, w_next_state;
    logic                 r_car_l, r_truck_l, r_oil_l, r_fuel_l, r_over_l;
    logic                 r_health_dec, r_truck_hit, r_fuel_refill, r_new_game;
    logic [COUNTER_W-1:0] r_frame_cnt;

    logic                 w_health_dec, w_truck_hit, w_fuel_refill, w_new_game;
    logic                 w_tmr_dec, w_tmr_load, w_tmr_clear, w_tmr_zero, w_tmr_done;
    logic [COUNTER_W-1:0] w_tmr_val, w_tmr_count;
    logic                 w_inv_dec, w_inv_load, w_inv_clear, w_inv_zero;
    logic [COUNTER_W-1:0] w_inv_count;
    logic                 w_hit;

    // Latches restart from the current input on startOfFrame so that a
    // collision coinciding with the frame pulse carries into the next frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_car_l   <= 1'b0;
            r_truck_l <= 1'b0;
            r_oil_l   <= 1'b0;
            r_fuel_l  <= 1'b0;
            r_over_l  <= 1'b0;
        end else if (startOfFrame) begin
            r_car_l   <= car_collision;
            r_truck_l <= truck_collision;
            r_oil_l   <= oil_collision;
            r_fuel_l  <= fuel_symbol_collision;
            r_over_l  <= gameOver;
        end else begin
            r_car_l   <= r_car_l   | car_collision;
            r_truck_l <= r_truck_l | truck_collision;
            r_oil_l   <= r_oil_l   | oil_collision;
            r_fuel_l  <= r_fuel_l  | fuel_symbol_collision;
            r_over_l  <= r_over_l  | gameOver;
        end
    end

    assign w_hit      = (r_car_l | r_truck_l) & w_inv_zero;
    // Zero also counts as done so a timer can never strand the FSM.
    assign w_tmr_done = (w_tmr_count == COUNTER_W'(1)) | w_tmr_zero;

    always_comb begin
        w_next_state  = r_state;
        w_health_dec  = 1'b0;
        w_truck_hit   = 1'b0;
        w_fuel_refill = 1'b0;
        w_new_game    = 1'b0;
        w_tmr_dec     = 1'b0;
        w_tmr_load    = 1'b0;
        w_tmr_clear   = 1'b0;
        w_tmr_val     = COUNTER_W'(CRASH_FRAMES);
        w_inv_dec     = 1'b0;
        w_inv_load    = 1'b0;
        w_inv_clear   = 1'b0;
        if (startOfFrame) begin
            unique case (r_state)
                IDLE, OVER: begin
                    w_tmr_clear = 1'b1;
                    w_inv_clear = 1'b1;
                    if (start_key) begin
                        w_next_state = RUN;
                        w_new_game   = 1'b1;
                    end
                end
                RUN, SPIN: begin
                    w_inv_dec     = 1'b1;
                    w_fuel_refill = r_fuel_l;
                    if (r_over_l) begin
                        w_next_state = OVER;
                    end else if (w_hit) begin
                        w_next_state = CRASH;
                        w_health_dec = 1'b1;
                        w_truck_hit  = r_truck_l;
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = COUNTER_W'(CRASH_FRAMES);
                    end else if (r_oil_l) begin
                        w_next_state = SPIN;
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = COUNTER_W'(OIL_FRAMES);
                    end else if (r_state == SPIN) begin
                        w_tmr_dec = 1'b1;
                        if (w_tmr_done) begin
                            w_next_state = RUN;
                        end
                    end
                end
                CRASH: begin
                    if (r_over_l) begin
                        w_next_state = OVER;
                    end else if (w_tmr_done) begin
                        w_next_state = RUN;
                        w_tmr_dec    = 1'b1;
                        w_inv_load   = 1'b1;
                    end else begin
                        w_tmr_dec = 1'b1;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
            // Entering game over drops any running timers at once.
            if ((w_next_state == OVER) || (w_next_state == IDLE)) begin
                w_tmr_clear = 1'b1;
                w_inv_clear = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= IDLE;
            r_health_dec  <= 1'b0;
            r_truck_hit   <= 1'b0;
            r_fuel_refill <= 1'b0;
            r_new_game    <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_state       <= w_next_state;
            r_health_dec  <= w_health_dec;
            r_truck_hit   <= w_truck_hit;
            r_fuel_refill <= w_fuel_refill;
            r_new_game    <= w_new_game;
            if (w_new_game) begin
                r_frame_cnt <= '0;
            end else if (startOfFrame) begin
                r_frame_cnt <= r_frame_cnt + COUNTER_W'(1);
            end
        end
    end

    frame_down_counter u_event_timer (
        .clk        (clk),
        .resetN     (resetN),
        .i_frame_en (w_tmr_dec),
        .i_load     (w_tmr_load),
        .i_clear    (w_tmr_clear),
        .i_load_val (w_tmr_val),
        .o_count    (w_tmr_count),
        .o_zero     (w_tmr_zero)
    );

    frame_down_counter u_invuln_timer (
        .clk        (clk),
        .resetN     (resetN),
        .i_frame_en (w_inv_dec),
        .i_load     (w_inv_load),
        .i_clear    (w_inv_clear),
        .i_load_val (COUNTER_W'(INVULN_FRAMES)),
        .o_count    (w_inv_count),
        .o_zero     (w_inv_zero)
    );

    assign state         = r_state;
    assign freeze        = (r_state == IDLE) | (r_state == CRASH) | (r_state == OVER);
    assign skid          = (r_state == SPIN);
    assign game_over_out = (r_state == OVER);
    assign invulnerable  = (w_inv_count != '0);
    assign blink         = invulnerable & (|(r_frame_cnt & (COUNTER_W'(1) << BLINK_BIT)));
    assign health_dec    = r_health_dec;
    assign truck_hit     = r_truck_hit;
    assign fuel_refill   = r_fuel_refill;
    assign new_game      = r_new_game;

endmodule

// File: tb/tb_collision_sequencer.sv
module tb_collision_sequencer;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_CRASH = 3'd2;
    localparam logic [2:0] S_SPIN  = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    logic       clk, resetN, sof, start_key;
    logic       car, truck, oil, fuel, gover;
    logic [2:0] state;
    logic       freeze, skid, inv, blink, hd, th, fr, ng, go;

    int n_checks = 0;
    int n_fail   = 0;

    collision_sequencer dut (
        .clk                   (clk),
        .resetN                (resetN),
        .startOfFrame          (sof),
        .start_key             (start_key),
        .car_collision         (car),
        .truck_collision       (truck),
        .oil_collision         (oil),
        .fuel_symbol_collision (fuel),
        .gameOver              (gover),
        .state                 (state),
        .freeze                (freeze),
        .skid                  (skid),
        .invulnerable          (inv),
        .blink                 (blink),
        .health_dec            (hd),
        .truck_hit             (th),
        .fuel_refill           (fr),
        .new_game              (ng),
        .game_over_out         (go)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed state %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Seven clocks per frame; returns at the negedge right after the frame edge.
    task automatic frame();
        step(6);
        sof = 1'b1;
        step(1);
        sof = 1'b0;
    endtask

    initial begin
        resetN = 1'b0; sof = 1'b0; start_key = 1'b0;
        car = 1'b0; truck = 1'b0; oil = 1'b0; fuel = 1'b0; gover = 1'b0;
        step(3);
        chk_st("rst_state", state, S_IDLE);
        chk1("rst_freeze", freeze, 1'b1);
        chk1("rst_skid", skid, 1'b0);
        chk1("rst_inv", inv, 1'b0);
        chk1("rst_blink", blink, 1'b0);
        chk1("rst_hd", hd, 1'b0);
        chk1("rst_th", th, 1'b0);
        chk1("rst_fr", fr, 1'b0);
        chk1("rst_ng", ng, 1'b0);
        chk1("rst_go", go, 1'b0);
        resetN = 1'b1;

        frame();
        chk_st("idle_hold", state, S_IDLE);
        start_key = 1'b1; frame(); start_key = 1'b0;
        chk_st("start_state", state, S_RUN);
        chk1("start_ng", ng, 1'b1);
        chk1("start_freeze", freeze, 1'b0);
        step(1);
        chk1("start_ng_once", ng, 1'b0);

        // Car hit: 64 frozen frames, then 96 frames of grace.
        car = 1'b1; step(3); car = 1'b0; frame();
        chk_st("car_state", state, S_CRASH);
        chk1("car_hd", hd, 1'b1);
        chk1("car_th", th, 1'b0);
        chk1("car_freeze", freeze, 1'b1);
        step(1);
        chk1("car_hd_once", hd, 1'b0);
        repeat (63) frame();
        chk_st("crash_f63", state, S_CRASH);
        chk1("crash_f63_freeze", freeze, 1'b1);
        frame();
        chk_st("crash_end", state, S_RUN);
        chk1("crash_end_inv", inv, 1'b1);
        chk1("crash_end_freeze", freeze, 1'b0);
        chk1("blink_fc65", blink, 1'b0);
        repeat (3) frame();
        chk1("blink_fc68", blink, 1'b1);
        repeat (4) frame();
        chk1("blink_fc72", blink, 1'b0);

        car = 1'b1; step(2); car = 1'b0; frame();
        chk_st("grace_state", state, S_RUN);
        chk1("grace_hd", hd, 1'b0);
        repeat (87) frame();
        chk1("inv_last", inv, 1'b1);
        frame();
        chk1("inv_expired", inv, 1'b0);
        chk1("inv_expired_blink", blink, 1'b0);

        car = 1'b1; truck = 1'b1; step(2); car = 1'b0; truck = 1'b0; frame();
        chk_st("truck_state", state, S_CRASH);
        chk1("truck_hd", hd, 1'b1);
        chk1("truck_th", th, 1'b1);
        step(1);
        chk1("truck_th_once", th, 1'b0);

        fuel = 1'b1; step(2); fuel = 1'b0; frame();
        chk_st("crash_fuel_state", state, S_CRASH);
        chk1("crash_fuel_fr", fr, 1'b0);

        gover = 1'b1; frame(); gover = 1'b0;
        chk_st("crash_over", state, S_OVER);
        chk1("crash_over_go", go, 1'b1);
        chk1("crash_over_freeze", freeze, 1'b1);
        start_key = 1'b1; frame(); start_key = 1'b0;
        chk_st("restart", state, S_RUN);
        chk1("restart_ng", ng, 1'b1);
        chk1("restart_go", go, 1'b0);
        chk1("restart_inv", inv, 1'b0);

        // Oil skid: full 32 frames.
        oil = 1'b1; step(2); oil = 1'b0; frame();
        chk_st("oil_state", state, S_SPIN);
        chk1("oil_skid", skid, 1'b1);
        chk1("oil_freeze", freeze, 1'b0);
        repeat (31) frame();
        chk_st("oil_f31", state, S_SPIN);
        frame();
        chk_st("oil_end", state, S_RUN);
        chk1("oil_end_skid", skid, 1'b0);

        // Second skid: fuel pickup, then crash on skid frame 10.
        oil = 1'b1; step(2); oil = 1'b0; frame();
        chk_st("oil2_state", state, S_SPIN);
        fuel = 1'b1; step(2); fuel = 1'b0; frame();
        chk1("spin_fr", fr, 1'b1);
        chk_st("spin_fr_state", state, S_SPIN);
        step(1);
        chk1("spin_fr_once", fr, 1'b0);
        repeat (8) frame();
        chk_st("spin_f9", state, S_SPIN);
        car = 1'b1; step(2); car = 1'b0; frame();
        chk_st("spin_crash", state, S_CRASH);
        chk1("spin_crash_hd", hd, 1'b1);
        chk1("spin_crash_skid", skid, 1'b0);

        step(3);
        resetN = 1'b0;
        step(1);
        chk_st("mid_rst_state", state, S_IDLE);
        chk1("mid_rst_freeze", freeze, 1'b1);
        chk1("mid_rst_hd", hd, 1'b0);
        resetN = 1'b1;
        start_key = 1'b1; frame(); start_key = 1'b0;
        chk_st("rst_restart", state, S_RUN);

        // Game over beats a simultaneous crash.
        gover = 1'b1; car = 1'b1; step(2); car = 1'b0; frame(); gover = 1'b0;
        chk_st("over_state", state, S_OVER);
        chk1("over_hd", hd, 1'b0);
        chk1("over_go", go, 1'b1);
        chk1("over_freeze", freeze, 1'b1);
        start_key = 1'b1; frame(); start_key = 1'b0;
        chk_st("over_restart", state, S_RUN);
        chk1("over_restart_ng", ng, 1'b1);

        // Collision coincident with startOfFrame waits one frame.
        step(6);
        car = 1'b1; sof = 1'b1; step(1); car = 1'b0; sof = 1'b0;
        chk_st("sof_coll_state", state, S_RUN);
        chk1("sof_coll_hd", hd, 1'b0);
        frame();
        chk_st("sof_coll_next", state, S_CRASH);
        chk1("sof_coll_next_hd", hd, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/collision_sequencer.md
# collision_sequencer

Frame-synchronous game-flow controller for the player car. It latches the per-pixel collision and game-over flags from the collision detector across each video frame and, once per frame, advances a state machine: idle, running, crash freeze, oil skid and game over. It produces the freeze, skid, invulnerability, blink and score-effect pulses consumed by the player mover, the health and fuel counters, and the road scroller. It sits between the collision detector and those per-object datapath blocks.

## Interface
- CRASH_FRAMES, 64: frames the game freezes after a car or truck hit (1..255)
- OIL_FRAMES, 32: frames of skid after an oil hit (1..255)
- INVULN_FRAMES, 96: post-crash grace frames during which crashes are ignored (1..255)
- BLINK_BIT, 2: bit of the frame counter that drives player blink
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-clk pulse per video frame
- start_key  in  1  level, start/restart request
- car_collision  in  1  player vs car/boar/edge overlap, pixel-rate
- truck_collision  in  1  player vs truck overlap, pixel-rate
- oil_collision  in  1  player vs oil overlap, pixel-rate
- fuel_symbol_collision  in  1  player vs fuel pickup overlap, pixel-rate
- gameOver  in  1  fuel or health exhausted, level
- state  out  3  encoded FSM state (game_pkg::seq_state_t)
- freeze  out  1  stop scrolling and player motion
- skid  out  1  player loses steering, drifts
- invulnerable  out  1  grace period active
- blink  out  1  player sprite hide request
- health_dec  out  1  one-clk pulse: subtract one health unit
- truck_hit  out  1  one-clk pulse, with health_dec: subtract an extra unit
- fuel_refill  out  1  one-clk pulse: refill fuel
- new_game  out  1  one-clk pulse: reset score/fuel/health/positions
- game_over_out  out  1  level, game-over screen

## Operation
- Sticky latches car_l, truck_l, oil_l, fuel_l, over_l set whenever the matching input is high. They clear on the startOfFrame cycle after evaluation. An input high in the same cycle as startOfFrame is kept for the next frame.
- All decisions are taken only on startOfFrame, using latch values from before that edge.
- IDLE (reset state): freeze=1. If start_key=1 at a frame → RUN and new_game.
- RUN, priority in this order:
  - over_l → OVER.
  - car_l|truck_l with invulnerable=0 → CRASH; health_dec; truck_hit if truck_l; crash counter loads CRASH_FRAMES.
  - oil_l → SPIN; counter loads OIL_FRAMES.
  - fuel_l, independently of the above, pulses fuel_refill in RUN and SPIN. It does not pulse in CRASH, IDLE or OVER.
- CRASH: freeze=1, latches ignored except over_l. The counter decrements per frame; at the frame where it reads 1 → RUN, and the invuln counter loads INVULN_FRAMES. over_l → OVER takes priority.
- SPIN: skid=1. over_l → OVER; non-invulnerable crash → CRASH (same actions as from RUN); otherwise decrement, reaching 1 → RUN. Oil in SPIN reloads OIL_FRAMES.
- Invuln counter decrements each frame in RUN/SPIN only. It holds in CRASH, clears in OVER/IDLE. invulnerable = counter≠0.
- blink = invulnerable & frame_cnt[BLINK_BIT]. frame_cnt is a free-running 8-bit count of startOfFrame, cleared on new_game.
- OVER: freeze=1, game_over_out=1. start_key at a frame → RUN with new_game; all counters and latches cleared.
- Counters are 8-bit unsigned and never wrap below 0.

## Timing
- Reset (resetN=0, async): state=IDLE, freeze=1, every other output 0, all counters and latches 0.
- State, levels and pulses are registered and update on the edge at which startOfFrame is sampled high. They are visible in the following cycle. Pulses last exactly one clk.
- Latency from collision pixel to response is at most one frame plus 1 clk.
- Reset asserted mid-crash or mid-skid aborts immediately to IDLE. No pulse is emitted.
- health_dec is issued at most once per frame. No repeat for the same crash, because CRASH/invulnerable masks it.

## Structure
- game_pkg holds: seq_state_t enum (IDLE, RUN, CRASH, SPIN, OVER; 3 bits) and the COUNTER_W=8 constant.
- Sub-module frame_down_counter: loadable 8-bit down-counter with frame enable, hold and zero flag. It is instantiated for the crash/skid timer and for the invuln timer.

## Test plan
- Reset, then start_key at frame 1 → RUN, single new_game pulse, freeze=0.
- car_collision 3 clk in frame N → at frame N+1 edge: CRASH, one health_dec, freeze=1 for 64 frames, then RUN with invulnerable=1 for 96 frames and blink toggling every 4 frames.
- truck_collision and car_collision together → health_dec and truck_hit in the same cycle. A second crash during grace → no pulse.
- oil_collision → skid=1 for 32 frames. Crash on frame 10 of skid → CRASH. fuel_collision during skid → fuel_refill once.
- gameOver together with car_collision in one frame → OVER, no health_dec, game_over_out=1. start_key → RUN, new_game.
- Collision in the same cycle as startOfFrame → acted on at the next frame, not the current one. resetN low mid-CRASH → IDLE next cycle.
